// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the CPU execute stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one shift-add or
// restoring-divide step per clock, 33 cycles from accepted start to done.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clock,
  input  logic          reset,
  hilo_muldiv_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               is_div_q,   is_div_d;
  logic               neg_q,      neg_d;
  logic               rem_neg_q,  rem_neg_d;
  logic [2*WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0]   opd_q,      opd_d;
  logic [WIDTH-1:0]   a_raw_q,    a_raw_d;
  logic [WIDTH-1:0]   hi_q,       hi_d;
  logic [WIDTH-1:0]   lo_q,       lo_d;
  logic               done_q,     done_d;

  // Operand conditioning: op[0]=1 selects the unsigned variants.
  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.src_a[WIDTH-1];
  assign b_neg     = is_signed & bus.src_b[WIDTH-1];
  assign mag_a     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
  assign mag_b     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;

  // Multiply step: acc holds {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc holds {partial remainder, dividend bits shifting into quotient}.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_fits;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign div_fits  = (div_shift >= {1'b0, opd_q});
  assign div_rem   = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_fits};

  // Sign correction applied once, on the FINISH edge.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               div_by_zero;

  assign prod_fix    = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix     = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix     = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  assign div_by_zero = (opd_q == '0);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves a latch behind.
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          is_div_d  = bus.op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          a_raw_d   = bus.src_a;
          if (bus.op[1]) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            opd_d = mag_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag_b};
            opd_d = mag_a;
          end
        end else begin
          if (bus.mthi) hi_d = bus.src_a;
          if (bus.mtlo) lo_d = bus.src_a;
        end
      end

      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_FINISH;
      end

      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_by_zero) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the datapath shift registers are reset too, so an aborted operation
  // leaves no stale partial result behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      opd_q     <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit: arithmetic corners,
// MTHI/MTLO, ignored requests while busy, and reset abort.
module tb_hilo_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  hilo_muldiv_if #(.WIDTH(32)) bif ();

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch at the next edge, then wait (bounded) for done; operands are
  // scrambled after acceptance to show they were latched.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int cycles;
    int busy_cnt;
    bif.start = 1'b1;
    bif.op    = op;
    bif.src_a = a;
    bif.src_b = b;
    @(posedge clock); #1;
    bif.start = 1'b0;
    bif.src_a = 32'hA5A5_5A5A;
    bif.src_b = 32'h5A5A_A5A5;
    cycles    = 0;
    busy_cnt  = bif.busy ? 1 : 0;
    while (!bif.done && cycles < 40) begin
      @(posedge clock); #1;
      cycles++;
      if (bif.busy) busy_cnt++;
    end
    check({tag, " latency"}, 64'(cycles), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " hi"}, 64'(bif.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bif.lo), 64'(exp_lo));
  endtask

  initial begin
    int   cycles;
    logic saw_done;

    bif.start = 1'b0;
    bif.op    = 2'b00;
    bif.src_a = '0;
    bif.src_b = '0;
    bif.mthi  = 1'b0;
    bif.mtlo  = 1'b0;
    reset     = 1'b1;
    #2 reset  = 1'b0;
    #1;
    check("reset busy", 64'(bif.busy), 64'd0);
    check("reset done", 64'(bif.done), 64'd0);
    check("reset hi",   64'(bif.hi),   64'd0);
    check("reset lo",   64'(bif.lo),   64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    // Each next start is raised in the done cycle, exercising back-to-back acceptance.
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100by7");
    run_op(OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "divu_by0");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0");

    // MTHI alone, then MTHI+MTLO together.
    bif.mthi  = 1'b1;
    bif.src_a = 32'h1234_5678;
    @(posedge clock); #1;
    bif.mthi  = 1'b0;
    check("mthi hi", 64'(bif.hi), 64'h1234_5678);
    check("mthi lo_kept", 64'(bif.lo), 64'hFFFF_FFFF);
    bif.mthi  = 1'b1;
    bif.mtlo  = 1'b1;
    bif.src_a = 32'hCAFE_0001;
    @(posedge clock); #1;
    bif.mthi  = 1'b0;
    bif.mtlo  = 1'b0;
    check("mthi_mtlo hi", 64'(bif.hi), 64'hCAFE_0001);
    check("mthi_mtlo lo", 64'(bif.lo), 64'hCAFE_0001);

    // DIVU 100/7 with a second start and an MTLO injected mid-calculation.
    bif.start = 1'b1;
    bif.op    = OP_DIVU;
    bif.src_a = 32'd100;
    bif.src_b = 32'd7;
    @(posedge clock); #1;
    bif.start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    bif.start = 1'b1;
    bif.op    = OP_MULTU;
    bif.src_a = 32'd3;
    bif.src_b = 32'd4;
    bif.mtlo  = 1'b1;
    @(posedge clock); #1;
    bif.start = 1'b0;
    bif.mtlo  = 1'b0;
    check("calc mtlo_ignored", 64'(bif.lo), 64'hCAFE_0001);
    check("calc busy", 64'(bif.busy), 64'd1);
    cycles = 0;
    while (!bif.done && cycles < 40) begin
      @(posedge clock); #1;
      cycles++;
    end
    check("busy_start latency", 64'(cycles), 64'd27);
    check("busy_start hi", 64'(bif.hi), 64'd2);
    check("busy_start lo", 64'(bif.lo), 64'd14);
    @(posedge clock); #1;
    check("busy_start no_requeue busy", 64'(bif.busy), 64'd0);
    check("busy_start no_requeue done", 64'(bif.done), 64'd0);

    // Start with MTHI in the same cycle: start wins, MTHI is dropped.
    bif.mthi = 1'b1;
    run_op(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, "start_over_mthi");
    bif.mthi = 1'b0;

    // Reset abort at cycle 10 of a DIVU.
    bif.start = 1'b1;
    bif.op    = OP_DIVU;
    bif.src_a = 32'd1000;
    bif.src_b = 32'd3;
    @(posedge clock); #1;
    bif.start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort busy", 64'(bif.busy), 64'd0);
    check("abort done", 64'(bif.done), 64'd0);
    check("abort hi",   64'(bif.hi),   64'd0);
    check("abort lo",   64'(bif.lo),   64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      if (bif.done || bif.busy) saw_done = 1'b1;
    end
    check("abort no_spurious_activity", 64'(saw_done), 64'd0);

    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7_after_reset");
    @(posedge clock); #1;
    check("post done_pulse_width", 64'(bif.done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit for the single-cycle MIPS datapath, with HI/LO registers.
- Sits beside the execute stage:
  - consumes the two register-read operands produced by the decode/register stage;
  - feeds HI/LO back for MFHI/MFLO writeback.
- Executes MULT, MULTU, DIV and DIVU over 33 cycles. The CPU stalls PC update while `busy` is high.
- Also handles MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch operation (sampled only in IDLE)
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  WIDTH  rs operand (multiplicand / dividend)
- src_b  input  WIDTH  rt operand (multiplier / divisor)
- mthi  input  1  write src_a into HI
- mtlo  input  1  write src_a into LO
- busy  output  1  operation in progress; CPU stall request
- done  output  1  one-cycle pulse when HI/LO are updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal shift registers=0.
  - Reset asserted mid-operation aborts the operation. No done pulse is produced.
- States:
  - IDLE -> CALC on start.
  - CALC -> FINISH when counter reaches WIDTH-1.
  - FINISH -> IDLE unconditionally.
- IDLE:
  - busy=0.
  - At an edge where start=1:
    - latch op;
    - latch |src_a| and |src_b| (magnitudes for signed ops, raw values for unsigned);
    - latch result-sign flags;
    - clear counter;
    - set busy=1.
  - mthi/mtlo at an edge with start=0 write src_a into HI/LO in that edge. Both may be asserted together.
  - start has priority: mthi/mtlo in the same cycle as start are dropped.
- CALC:
  - One iteration per edge, WIDTH edges total.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per edge, MSB first.
  - start, mthi and mtlo are ignored.
- FINISH, one edge:
  - apply sign correction;
  - write hi/lo;
  - busy->0, done->1 for exactly one cycle.
- Latency: start accepted at edge E0; busy=1 after E0 through E33; hi/lo valid and done=1 in the cycle after E33.
- A new start may be accepted in the cycle where done=1, since the state is IDLE.
- Signed multiply: product negated (two's complement, 2*WIDTH bits) when operand signs differ. hi=upper WIDTH bits, lo=lower WIDTH bits.
- Signed divide:
  - quotient negated when signs differ;
  - remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
- Divide by zero, signed or unsigned: lo=all-ones, hi=src_a as latched (original, not magnitude). Still takes the full 33 cycles.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Magnitude arithmetic is unsigned and correct for 0x80000000.
- hi/lo hold their values at all times except on FINISH, MTHI/MTLO or reset.

Test Plan:
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT src_a=0xFFFFFFFD (-3), src_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI src_a=0x12345678 in IDLE -> hi=0x12345678 next cycle. start with operands 3, 4 while busy -> ignored, first result unchanged. mtlo asserted during CALC -> lo unchanged until FINISH.
- reset driven low at cycle 10 of a DIVU -> busy=0, hi=lo=0 immediately. After release, a fresh MULTU 6x7 -> lo=42, hi=0 after 33 cycles with no spurious done.
